// File: rtl/game_match_if.sv
//------------------------------------------------------------------------------
// Module   : game_match_if
// Purpose  : Control and status bundle between a game_match core and its host.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface game_match_if #(
    parameter int WIDTH   = 4,
    parameter int SCORE_W = 4
);
    logic               start;
    logic               init;
    logic [WIDTH-1:0]   val;
    logic               en;
    logic [1:0]         ctrl;
    logic               ack;
    logic [WIDTH-1:0]   count;
    logic               loser;
    logic               winner;
    logic [SCORE_W-1:0] loser_score;
    logic [SCORE_W-1:0] winner_score;
    logic               gameover;
    logic [1:0]         who;
    logic               busy;

    modport master (
        output start, init, val, en, ctrl, ack,
        input  count, loser, winner, loser_score, winner_score, gameover, who, busy
    );

    modport slave (
        input  start, init, val, en, ctrl, ack,
        output count, loser, winner, loser_score, winner_score, gameover, who, busy
    );
endinterface

`default_nettype wire

// File: rtl/game_match.sv
//------------------------------------------------------------------------------
// Module   : game_match
// Purpose  : Wrapping up/down counter game; hitting 0 or all-ones scores a side,
//            first side to TARGET ends the match.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module game_match #(
    parameter int WIDTH   = 4,
    parameter int SCORE_W = 4,
    parameter int TARGET  = 15,
    parameter int STEP    = 2
) (
    input  wire             clk,
    input  wire             rst_n,
    game_match_if.slave     bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_OVER = 2'd2
    } state_t;

    localparam logic [1:0]         C_WHO_NONE  = 2'b00;
    localparam logic [1:0]         C_WHO_LOSER = 2'b01;
    localparam logic [1:0]         C_WHO_WIN   = 2'b10;
    localparam logic [WIDTH-1:0]   C_STEP      = WIDTH'(STEP);
    localparam logic [WIDTH-1:0]   C_ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0]   C_ZERO      = '0;
    localparam logic [WIDTH-1:0]   C_ALL1      = '1;
    localparam logic [SCORE_W-1:0] C_TARGET    = SCORE_W'(TARGET);
    localparam logic [SCORE_W-1:0] C_SONE      = SCORE_W'(1);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [SCORE_W-1:0] lscore_q, lscore_d;
    logic [SCORE_W-1:0] wscore_q, wscore_d;
    logic [1:0]         who_q, who_d;

    logic [WIDTH-1:0]   w_play_next;
    logic [SCORE_W-1:0] w_lscore_inc;
    logic [SCORE_W-1:0] w_wscore_inc;
    logic               w_loser_hit;
    logic               w_winner_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            lscore_q <= '0;
            wscore_q <= '0;
            who_q    <= C_WHO_NONE;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lscore_q <= lscore_d;
            wscore_q <= wscore_d;
            who_q    <= who_d;
        end
    end

    // Counter value a PLAY edge would produce; reload beats enable.
    always_comb begin
        w_play_next = count_q;
        if (bus.init) begin
            w_play_next = bus.val;
        end else if (bus.en) begin
            unique case (bus.ctrl)
                2'b00:   w_play_next = count_q + C_ONE;
                2'b01:   w_play_next = count_q + C_STEP;
                2'b10:   w_play_next = count_q - C_ONE;
                default: w_play_next = count_q - C_STEP;
            endcase
        end
    end

    // Only arriving at an end value scores, never sitting on one.
    assign w_loser_hit  = (w_play_next == C_ZERO) && (count_q != C_ZERO);
    assign w_winner_hit = (w_play_next == C_ALL1) && (count_q != C_ALL1);
    assign w_lscore_inc = lscore_q + C_SONE;
    assign w_wscore_inc = wscore_q + C_SONE;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        lscore_d = lscore_q;
        wscore_d = wscore_q;
        who_d    = who_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_PLAY;
                    lscore_d = '0;
                    wscore_d = '0;
                    who_d    = C_WHO_NONE;
                    if (bus.init) begin
                        count_d = bus.val;
                    end
                end
            end
            S_PLAY: begin
                count_d = w_play_next;
                if (w_loser_hit) begin
                    lscore_d = w_lscore_inc;
                    if (w_lscore_inc == C_TARGET) begin
                        state_d = S_OVER;
                        who_d   = C_WHO_LOSER;
                    end
                end else if (w_winner_hit) begin
                    wscore_d = w_wscore_inc;
                    if (w_wscore_inc == C_TARGET) begin
                        state_d = S_OVER;
                        who_d   = C_WHO_WIN;
                    end
                end
            end
            S_OVER: begin
                if (bus.ack) begin
                    state_d = S_IDLE;
                    who_d   = C_WHO_NONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.count        = count_q;
    assign bus.loser        = (count_q == C_ZERO);
    assign bus.winner       = (count_q == C_ALL1);
    assign bus.loser_score  = lscore_q;
    assign bus.winner_score = wscore_q;
    assign bus.gameover     = (state_q == S_OVER);
    assign bus.busy         = (state_q == S_PLAY);
    assign bus.who          = who_q;

endmodule

`default_nettype wire

// File: tb/tb_game_match.sv
//------------------------------------------------------------------------------
// Module   : tb_game_match
// Purpose  : Directed self-checking bench for game_match (TARGET=3, STEP=2).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_game_match;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    game_match_if #(.WIDTH(4), .SCORE_W(4)) bus ();

    game_match #(
        .WIDTH   (4),
        .SCORE_W (4),
        .TARGET  (3),
        .STEP    (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: count, loser_score, winner_score, who, gameover, busy, loser, winner
    logic [17:0] obs;
    assign obs = {bus.count, bus.loser_score, bus.winner_score, bus.who,
                  bus.gameover, bus.busy, bus.loser, bus.winner};

    task automatic drive(input logic st, input logic in, input logic [3:0] v,
                         input logic e, input logic [1:0] c, input logic a);
        bus.start = st;
        bus.init  = in;
        bus.val   = v;
        bus.en    = e;
        bus.ctrl  = c;
        bus.ack   = a;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 0, 4'd0, 0, 2'b00, 0);
        #2;
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset: got %h expected %h", obs, {4'd0, 4'd0, 4'd0, 2'b00, 4'b0010});
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset: busy %b count %0d expected 0 0", bus.busy, bus.count);
        end
    endtask

    task automatic test_wrap();
        drive(1, 1, 4'd14, 0, 2'b00, 0);
        tick();
        checks++;
        if (obs !== {4'd14, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL start_load: got %h expected %h", obs, {4'd14, 8'd0, 2'b00, 4'b0100});
        end
        drive(0, 0, 4'd0, 1, 2'b00, 0);
        tick();
        checks++;
        if (obs !== {4'd15, 4'd0, 4'd1, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL wrap_winner: got %h expected %h", obs, {4'd15, 4'd0, 4'd1, 2'b00, 4'b0101});
        end
        tick();
        checks++;
        if (obs !== {4'd0, 4'd1, 4'd1, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wrap_loser: got %h expected %h", obs, {4'd0, 4'd1, 4'd1, 2'b00, 4'b0110});
        end
    endtask

    task automatic test_priority();
        drive(0, 1, 4'd5, 0, 2'b00, 0);
        tick();
        checks++;
        if (bus.count !== 4'd5 || bus.loser_score !== 4'd1) begin
            errors++;
            $display("FAIL load5: count %0d ls %0d expected 5 1", bus.count, bus.loser_score);
        end
        drive(0, 1, 4'd0, 1, 2'b01, 0);
        tick();
        checks++;
        if (bus.count !== 4'd0 || bus.loser_score !== 4'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL init_priority: count %0d ls %0d busy %b expected 0 2 1",
                     bus.count, bus.loser_score, bus.busy);
        end
    endtask

    task automatic test_large_step();
        drive(0, 1, 4'd1, 0, 2'b00, 0);
        tick();
        drive(0, 0, 4'd0, 1, 2'b11, 0);
        tick();
        checks++;
        if (bus.count !== 4'd15 || bus.winner_score !== 4'd2 || bus.loser_score !== 4'd2) begin
            errors++;
            $display("FAIL step_down: count %0d ws %0d ls %0d expected 15 2 2",
                     bus.count, bus.winner_score, bus.loser_score);
        end
    endtask

    task automatic test_edge_only();
        drive(0, 0, 4'd0, 0, 2'b00, 0);
        for (int i = 0; i < 5; i++) tick();
        checks++;
        if (bus.count !== 4'd15 || bus.winner_score !== 4'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_no_score: count %0d ws %0d expected 15 2", bus.count, bus.winner_score);
        end
        drive(0, 1, 4'd15, 0, 2'b00, 0);
        tick();
        checks++;
        if (bus.count !== 4'd15 || bus.winner_score !== 4'd2 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL reload_no_score: count %0d ws %0d expected 15 2", bus.count, bus.winner_score);
        end
    endtask

    task automatic test_match_end();
        drive(0, 0, 4'd0, 1, 2'b00, 0);
        tick();
        checks++;
        if (obs !== {4'd0, 4'd3, 4'd2, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL match_end: got %h expected %h", obs, {4'd0, 4'd3, 4'd2, 2'b01, 4'b1010});
        end
    endtask

    task automatic test_over_freeze();
        drive(1, 1, 4'd7, 1, 2'b01, 0);
        tick();
        tick();
        checks++;
        if (obs !== {4'd0, 4'd3, 4'd2, 2'b01, 1'b1, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL over_freeze: got %h expected %h", obs, {4'd0, 4'd3, 4'd2, 2'b01, 4'b1010});
        end
        drive(0, 0, 4'd0, 0, 2'b00, 1);
        tick();
        checks++;
        if (obs !== {4'd0, 4'd3, 4'd2, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL ack_idle: got %h expected %h", obs, {4'd0, 4'd3, 4'd2, 2'b00, 4'b0010});
        end
        drive(0, 1, 4'd9, 1, 2'b01, 1);
        tick();
        checks++;
        if (obs !== {4'd0, 4'd3, 4'd2, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL idle_ignore: got %h expected %h", obs, {4'd0, 4'd3, 4'd2, 2'b00, 4'b0010});
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 0, 4'd9, 0, 2'b00, 0);
        tick();
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL restart_hold: got %h expected %h", obs, {4'd0, 8'd0, 2'b00, 4'b0110});
        end
    endtask

    task automatic test_async_abort();
        drive(0, 1, 4'd14, 0, 2'b00, 0);
        tick();
        drive(0, 0, 4'd0, 1, 2'b00, 0);
        tick();
        tick();
        tick();
        drive(0, 0, 4'd0, 1, 2'b10, 0);
        tick();
        checks++;
        if (bus.loser_score !== 4'd2 || bus.winner_score !== 4'd1 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort: ls %0d ws %0d busy %b expected 2 1 1",
                     bus.loser_score, bus.winner_score, bus.busy);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== {4'd0, 4'd0, 4'd0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_abort: got %h expected %h", obs, {14'd0, 4'b0010});
        end
        drive(0, 0, 4'd0, 0, 2'b00, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus.busy !== 1'b0 || bus.gameover !== 1'b0 || bus.count !== 4'd0) begin
            errors++;
            $display("FAIL post_abort_idle: busy %b over %b count %0d expected 0 0 0",
                     bus.busy, bus.gameover, bus.count);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_wrap();
        test_priority();
        test_large_step();
        test_edge_only();
        test_match_end();
        test_over_freeze();
        test_back_to_back();
        test_async_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
